// File: rtl/weight_pingpong_buffer_if.sv
// Handshake and bus bundle for the weight ping-pong buffer: streaming write side
// plus banked read side with explicit release.
interface weight_pingpong_buffer_if #(
  parameter int LANE_NUM      = 9,
  parameter int LANE_IN_WIDTH = 36,
  parameter int RATIO         = 4,
  parameter int RD_ADDR_WIDTH = 8
);
  localparam int WR_WIDTH = LANE_NUM * LANE_IN_WIDTH;
  localparam int RD_WIDTH = WR_WIDTH * RATIO;

  logic [WR_WIDTH-1:0]    wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic                   wr_last;
  logic                   rd_bank_ready;
  logic [RD_ADDR_WIDTH:0] rd_rows;
  logic                   rd_req;
  logic [RD_ADDR_WIDTH-1:0] rd_addr;
  logic [RD_WIDTH-1:0]    rd_data;
  logic                   rd_valid;
  logic                   rd_release;

  modport master (
    output wr_data, wr_valid, wr_last, rd_req, rd_addr, rd_release,
    input  wr_ready, rd_bank_ready, rd_rows, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, wr_last, rd_req, rd_addr, rd_release,
    output wr_ready, rd_bank_ready, rd_rows, rd_data, rd_valid
  );
endinterface

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: packs RATIO narrow words per wide row into one bank
// while the PE array reads the other bank with a fixed 2-cycle latency.
module weight_pingpong_buffer #(
  parameter int LANE_NUM      = 9,
  parameter int LANE_IN_WIDTH = 36,
  parameter int RATIO         = 4,
  parameter int RD_DEPTH      = 256,
  parameter int RD_ADDR_WIDTH = $clog2(RD_DEPTH)
) (
  input logic clk,
  input logic rst,
  weight_pingpong_buffer_if.slave bus
);
  localparam int WR_WIDTH = LANE_NUM * LANE_IN_WIDTH;
  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam int SLOT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_state_t;

  bank_state_t              state_q   [2];
  bank_state_t              state_nxt [2];
  logic                     wb_q, rb_q, wb_nxt, rb_nxt;
  logic [SLOT_W-1:0]        slot_q;
  logic [RD_ADDR_WIDTH-1:0] row_q;
  logic [RD_ADDR_WIDTH:0]   rows_q [2];

  logic [WR_WIDTH-1:0]      pack_q [RATIO];
  logic [RD_WIDTH-1:0]      mem [2*RD_DEPTH];
  logic [RD_WIDTH-1:0]      wr_row;
  logic [RD_WIDTH-1:0]      ram_p0;
  logic                     vld_p0, oob_p0;

  logic accept, last_slot, row_wr, close, rd_fire, rel_fire;

  assign bus.wr_ready      = (state_q[wb_q] == EMPTY) || (state_q[wb_q] == FILLING);
  assign bus.rd_bank_ready = (state_q[rb_q] == FULL)  || (state_q[rb_q] == READING);
  assign bus.rd_rows       = bus.rd_bank_ready ? rows_q[rb_q] : '0;

  assign accept    = bus.wr_valid & bus.wr_ready;
  assign last_slot = (slot_q == SLOT_W'(RATIO - 1));
  assign row_wr    = accept & (last_slot | bus.wr_last);
  assign close     = accept & (bus.wr_last |
                               (last_slot & (row_q == RD_ADDR_WIDTH'(RD_DEPTH - 1))));
  assign rd_fire   = bus.rd_req & bus.rd_bank_ready;
  assign rel_fire  = bus.rd_release & bus.rd_bank_ready;

  // Row = earlier slots from the packing register, current word, zeros above it
  always_comb begin
    wr_row = '0;
    for (int s = 0; s < RATIO; s++) begin
      if (SLOT_W'(s) < slot_q)
        wr_row[s*WR_WIDTH +: WR_WIDTH] = pack_q[s];
      else if (SLOT_W'(s) == slot_q)
        wr_row[s*WR_WIDTH +: WR_WIDTH] = bus.wr_data;
    end
  end

  // Writer and reader never act on the same bank in one cycle, so both may fire
  always_comb begin
    state_nxt[0] = state_q[0];
    state_nxt[1] = state_q[1];
    wb_nxt       = wb_q;
    rb_nxt       = rb_q;
    if (accept) begin
      if (close) begin
        state_nxt[wb_q] = FULL;
        wb_nxt          = ~wb_q;
      end else begin
        state_nxt[wb_q] = FILLING;
      end
    end
    if (rel_fire) begin
      state_nxt[rb_q] = EMPTY;
      rb_nxt          = ~rb_q;
    end else if (rd_fire && state_q[rb_q] == FULL) begin
      state_nxt[rb_q] = READING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      slot_q     <= '0;
      row_q      <= '0;
      rows_q[0]  <= '0;
      rows_q[1]  <= '0;
      vld_p0     <= 1'b0;
      oob_p0     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      state_q[0] <= state_nxt[0];
      state_q[1] <= state_nxt[1];
      wb_q       <= wb_nxt;
      rb_q       <= rb_nxt;
      if (accept) begin
        if (close) begin
          rows_q[wb_q] <= {1'b0, row_q} + 1'b1;
          slot_q       <= '0;
          row_q        <= '0;
        end else if (last_slot) begin
          slot_q <= '0;
          row_q  <= row_q + 1'b1;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end
      // p0: RAM read issued, range check captured alongside
      vld_p0 <= rd_fire;
      oob_p0 <= ({1'b0, bus.rd_addr} >= bus.rd_rows);
      // p1: output register, holds its value between valid reads
      bus.rd_valid <= vld_p0;
      if (vld_p0)
        bus.rd_data <= oob_p0 ? '0 : ram_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pack_q[slot_q] <= bus.wr_data;
    if (row_wr)
      mem[{wb_q, row_q}] <= wr_row;
    if (rd_fire)
      ram_p0 <= mem[{rb_q, bus.rd_addr}];
  end
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Randomized and directed bench for weight_pingpong_buffer against a tile-queue
// reference model (completed tiles waiting for the reader, plus the tile being loaded).
module tb_weight_pingpong_buffer;
  localparam int LANE_NUM      = 2;
  localparam int LANE_IN_WIDTH = 4;
  localparam int RATIO         = 4;
  localparam int RD_DEPTH      = 4;
  localparam int RD_ADDR_WIDTH = 2;
  localparam int TILE_WORDS    = RATIO * RD_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_pingpong_buffer_if #(
    .LANE_NUM(LANE_NUM), .LANE_IN_WIDTH(LANE_IN_WIDTH),
    .RATIO(RATIO), .RD_ADDR_WIDTH(RD_ADDR_WIDTH)
  ) bus ();

  weight_pingpong_buffer #(
    .LANE_NUM(LANE_NUM), .LANE_IN_WIDTH(LANE_IN_WIDTH), .RATIO(RATIO),
    .RD_DEPTH(RD_DEPTH), .RD_ADDR_WIDTH(RD_ADDR_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: tile image = word k at bits [8k +: 8], zero padded
  logic [127:0] tile_q [$];
  int           rows_q [$];
  logic [127:0] cur_tile;
  int           n_cur;
  int           due_q [$];
  logic [31:0]  dat_q [$];
  logic [31:0]  last_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    tile_q.delete();
    rows_q.delete();
    due_q.delete();
    dat_q.delete();
    cur_tile  = '0;
    n_cur     = 0;
    last_data = '0;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic rq, input logic [1:0] ra, input logic rel);
    bus.wr_valid   = v;
    bus.wr_data    = d;
    bus.wr_last    = l;
    bus.rd_req     = rq;
    bus.rd_addr    = ra;
    bus.rd_release = rel;
  endtask

  // One clock cycle: compare current outputs with the model, then advance both
  task automatic step();
    logic         exp_v, acc, rel, do_close;
    logic [127:0] t;
    logic [31:0]  d;
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    if (exp_v) begin
      last_data = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    check_eq("rd_valid", bus.rd_valid, exp_v);
    check_eq("rd_data", bus.rd_data, last_data);
    check_eq("wr_ready", bus.wr_ready, tile_q.size() < 2);
    check_eq("rd_bank_ready", bus.rd_bank_ready, tile_q.size() > 0);
    check_eq("rd_rows", bus.rd_rows, (tile_q.size() > 0) ? rows_q[0] : 0);

    acc = bus.wr_valid && (tile_q.size() < 2);
    rel = bus.rd_release && (tile_q.size() > 0);
    if (bus.rd_req && tile_q.size() > 0) begin
      t = tile_q[0] >> (32 * int'(bus.rd_addr));
      d = (int'(bus.rd_addr) < rows_q[0]) ? t[31:0] : 32'h0;
      due_q.push_back(cyc + 2);
      dat_q.push_back(d);
    end
    do_close = 1'b0;
    if (acc) begin
      cur_tile = cur_tile | (128'(bus.wr_data) << (8 * n_cur));
      n_cur++;
      do_close = bus.wr_last || (n_cur == TILE_WORDS);
    end

    @(posedge clk);
    if (rel) begin
      void'(tile_q.pop_front());
      void'(rows_q.pop_front());
    end
    if (do_close) begin
      tile_q.push_back(cur_tile);
      rows_q.push_back((n_cur + RATIO - 1) / RATIO);
      cur_tile = '0;
      n_cur    = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_rd_valid", bus.rd_valid, 1'b0);
    check_eq("rst_bank_ready", bus.rd_bank_ready, 1'b0);
    check_eq("rst_wr_ready", bus.wr_ready, 1'b1);
    check_eq("rst_rd_rows", bus.rd_rows, 0);
    @(posedge clk);
    @(negedge clk);
    model_clear();
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    rst = 1'b0;
    cyc++;
  endtask

  logic [31:0] pexp [4];

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    check_eq("rst_rd_data", bus.rd_data, 0);

    // Full tile, auto-close on the 16th word
    for (int k = 1; k <= TILE_WORDS; k++) begin
      drive(1, 8'(k), 0, 0, 2'd0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    check_eq("s1_bank_ready", bus.rd_bank_ready, 1'b1);
    check_eq("s1_rows", bus.rd_rows, 4);
    check_eq("s1_wr_ready", bus.wr_ready, 1'b1);
    drive(0, 8'h00, 0, 1, 2'd0, 0);
    step();
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    step();
    check_eq("s1_row0_valid", bus.rd_valid, 1'b1);
    check_eq("s1_row0", bus.rd_data, 32'h04030201);

    // Second tile (partial) fills the other bank: backpressure
    for (int k = 1; k <= 5; k++) begin
      drive(1, 8'(8'hA0 + k), k == 5, 0, 2'd0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    check_eq("bp_wr_ready", bus.wr_ready, 1'b0);
    drive(1, 8'hEE, 0, 0, 2'd0, 1);
    step();
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    check_eq("bp_release_wr_ready", bus.wr_ready, 1'b1);
    check_eq("bp_release_rows", bus.rd_rows, 2);

    // Back-to-back reads 3,2,1,0 of the partial tile
    pexp[0] = 32'h0; pexp[1] = 32'h0; pexp[2] = 32'h000000A5; pexp[3] = 32'hA4A3A2A1;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        check_eq("pipe_valid", bus.rd_valid, 1'b1);
        check_eq("pipe_data", bus.rd_data, pexp[i-2]);
      end
      drive(0, 8'h00, 0, i < 4, (i < 4) ? 2'(3 - i) : 2'd0, 0);
      step();
    end
    check_eq("pipe_end_valid", bus.rd_valid, 1'b0);

    // Release everything, then a request with no ready bank
    drive(0, 8'h00, 0, 0, 2'd0, 1);
    step();
    drive(0, 8'h00, 0, 1, 2'd1, 0);
    step();
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    step();
    check_eq("noready_valid", bus.rd_valid, 1'b0);

    // Close and release on the same edge
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'(8'hB0 + k), k == 2, 0, 2'd0, 0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'(8'hC0 + k), k == 5, 0, 2'd0, k == 5);
      step();
    end
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    check_eq("sim_bank_ready", bus.rd_bank_ready, 1'b1);
    check_eq("sim_rows", bus.rd_rows, 2);
    check_eq("sim_wr_ready", bus.wr_ready, 1'b1);

    // Reset with 6 words packed and a read in flight
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'(8'hD0 + k), 0, 0, 2'd0, 0);
      step();
    end
    drive(0, 8'h00, 0, 1, 2'd1, 0);
    step();
    do_reset();
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'(8'h11 * k), k == 4, 0, 2'd0, 0);
      step();
    end
    drive(0, 8'h00, 0, 1, 2'd0, 0);
    step();
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    step();
    check_eq("post_rst_row0", bus.rd_data, 32'h44332211);
    check_eq("post_rst_rows", bus.rd_rows, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              $urandom_range(0, 19) == 0);
        step();
      end
    end
    drive(0, 8'h00, 0, 0, 2'd0, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/weight_pingpong_buffer.md
# weight_pingpong_buffer

Double-buffered weight store that sits between the weight loader and the PE array. Its write side is a narrow streaming port with `valid`/`ready` handshake. Incoming lane words are packed `RATIO`:1 into wide rows and written into one of two internal banks. The read side addresses the other bank with a fixed 2-cycle latency and releases it explicitly, so weight loading for tile N+1 overlaps computation on tile N.

## Interface
Parameters:
- `LANE_NUM`, 9: parallel lanes.
- `LANE_IN_WIDTH`, 36: bits per lane per write word.
- `RATIO`, 4: write words packed per read row.
- `RD_DEPTH`, 256: rows per bank.
- `RD_ADDR_WIDTH`, 8: `$clog2(RD_DEPTH)`.
- Derived widths:
  - `WR_WIDTH` = `LANE_NUM*LANE_IN_WIDTH`.
  - `RD_WIDTH` = `WR_WIDTH*RATIO`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  `WR_WIDTH`  write word.
- `wr_valid`  in  1  write word present.
- `wr_ready`  out  1  write word accepted when `wr_valid & wr_ready`.
- `wr_last`  in  1  the accepted word closes the current bank.
- `rd_bank_ready`  out  1  the read bank holds a complete tile.
- `rd_rows`  out  `RD_ADDR_WIDTH+1`  valid row count of the read bank.
- `rd_req`  in  1  read request.
- `rd_addr`  in  `RD_ADDR_WIDTH`  row address for `rd_req`.
- `rd_data`  out  `RD_WIDTH`  row data.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_release`  in  1  the consumer is finished with the read bank.

## Operation
- **Storage.** Two banks of `RD_DEPTH` x `RD_WIDTH`, inferred synchronous-read RAM.
- **Pointers.** `wb` is the write-bank pointer and `rb` is the read-bank pointer. Both are 0 after reset.
- **Bank states.** Each bank has its own state: `EMPTY`, `FILLING`, `FULL`, `READING`.
- **Bank transitions.**
  - `EMPTY` goes to `FILLING` on the first accepted word.
  - `FILLING` goes to `FULL` when the bank is closed.
  - `FULL` goes to `READING` on the first `rd_req`.
  - `FULL` or `READING` goes to `EMPTY` on `rd_release`.
- **Packing.**
  - Accepted word k of a tile goes to row k/`RATIO`, slot k%`RATIO`.
  - Slot 0 occupies the LSBs; within each slot, lane i occupies bits `[i*LANE_IN_WIDTH +: LANE_IN_WIDTH]`.
  - A packing register holds up to `RATIO-1` words.
  - The row is written to RAM on the edge that accepts slot `RATIO-1`, or on the edge that accepts `wr_last`. The row is assembled combinationally from the packing register plus the current word.
  - Slots not yet filled when `wr_last` arrives are written as zero.
- **Bank close.** The bank closes on accepted `wr_last`, or automatically when word `RD_DEPTH*RATIO-1` is accepted.
  - On close, `rd_rows` for that bank is latched as ceil(words/`RATIO`).
  - `wb` toggles.
  - The packing register and the word counter clear.
- **`wr_ready`.** High iff bank `wb` is `EMPTY` or `FILLING`. It is low while both banks await the reader.
- **`rd_bank_ready`.** High iff bank `rb` is `FULL` or `READING`. `rd_rows` shows that bank's count, and is 0 otherwise.
- **Reads.**
  - `rd_req` is ignored (no `rd_valid`) when `rd_bank_ready`=0.
  - When `rd_addr` >= `rd_rows`, the read returns all-zero data with `rd_valid`=1.
  - Back-to-back requests on every cycle are supported.
- **Release.**
  - `rd_release` with `rd_bank_ready`=1 sets bank `rb` to `EMPTY` and toggles `rb`. Otherwise it is ignored.
  - Reads already issued complete with the old bank's data.
- **Simultaneous events.**
  - A write-side close and a read-side release on the same edge both take effect.
  - If the release frees bank `wb`, `wr_ready` rises on the next cycle.
  - `rd_req` together with `rd_release` in the same cycle: the request is served from the old bank.
- **Reset.** Reset mid-operation discards all tiles, in-flight reads and packing state.

## Timing
- **Reset values:**
  - `wr_ready`=1 (banks `EMPTY`).
  - `rd_bank_ready`=0, `rd_rows`=0.
  - `rd_valid`=0, `rd_data`=0.
  - Internal: state `EMPTY` for both banks, counters 0.
- **Write throughput.** One word per cycle while `wr_ready`=1, with no bubbles across row boundaries.
- **Close to readable.** `rd_bank_ready` rises on the cycle after the closing word is accepted.
- **Read latency.** A request in cycle t:
  - The RAM is read at the end of t.
  - The output register loads at the end of t+1.
  - `rd_valid`/`rd_data` are visible in cycle t+2 for exactly one cycle.
  - `rd_data` holds its last value when `rd_valid`=0.
- **Release to writable.** Release in cycle t makes the bank `EMPTY` in t+1. The earliest write to that bank is at the end of t+1, so no read/write hazard exists for requests issued at or before t.

## Test plan
All scenarios use `LANE_NUM`=2, `LANE_IN_WIDTH`=4, `RATIO`=4, `RD_DEPTH`=4.
- **Full tile, auto-close.**
  - Stimulus: after reset, stream words 0x01..0x10 (16 words) with no `wr_last`.
  - Required: the bank auto-closes; `rd_bank_ready`=1 at cycle 17; `rd_rows`=4.
  - Required: a read of row 0 returns 0x04030201 in 2 cycles.
  - Required: `wr_ready` stays 1 because bank 1 is `EMPTY`.
- **Partial tile, zero pad.**
  - Stimulus: stream 5 words 0xA1..0xA5 with `wr_last` on the 5th.
  - Required: `rd_rows`=2; row 1 = 0x000000A5.
  - Required: a read at `rd_addr`=3 returns 0 with `rd_valid`=1.
- **Backpressure.**
  - Stimulus: fill two tiles without releasing.
  - Required: `wr_ready`=0 after the second close.
  - Stimulus: assert `rd_release`.
  - Required: `wr_ready`=1 the next cycle; `rd_rows` switches to the second tile's count.
- **Read pipeline.**
  - Stimulus: `rd_req` on 4 consecutive cycles, addresses 3,2,1,0.
  - Required: `rd_valid` is high for 4 consecutive cycles starting 2 cycles later, with data in request order.
  - Required: `rd_req` while `rd_bank_ready`=0 yields no `rd_valid`.
- **Simultaneous close and release.**
  - Stimulus: `wr_last` accepted on the same edge as `rd_release`.
  - Required: both pointers toggle; `rd_bank_ready`=1 with the new tile's `rd_rows` on the next cycle.
- **Reset mid-operation.**
  - Stimulus: assert `rst` after 6 words plus one pending read.
  - Required: `rd_valid`=0, `rd_bank_ready`=0, `wr_ready`=1.
  - Required: the next tile starts at row 0, slot 0.
